lsu_axi_master: RTL and testbench

AXI4-Lite initiator for the core's load/store unit.
- Takes one load or store request at a time from the execute stage and drives the read or write channels to a data-memory responder.
- Returns aligned, sign/zero-extended load data or a store acknowledgment, plus an error flag.
- Sits between the LSU pipeline stage and the data-memory/crossbar slave port; all channel signals use the team's 32-bit data, 8-bit wstrb memory interface.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_axi_master_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 31 +++
 rtl/lsu_axi_master.sv | 212 +++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit AXI4-Lite initiator.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RESP
  } lsu_state_e;

  localparam logic [1:0] SZ_B      = 2'd0;
  localparam logic [1:0] SZ_H      = 2'd1;
  localparam logic [1:0] SZ_W      = 2'd2;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Byte-lane strobe for a 32-bit beat; reserved size yields no lanes.
  function automatic logic [3:0] strb_gen(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << off;
  endfunction

  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00)) || (size == 2'd3);
  endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite read/write channel bundle between the LSU initiator and data memory.
// Every channel follows valid/ready: a transfer happens on a rising clk edge where both are
// high, and once valid is raised it and its payload stay unchanged until that edge.
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 8
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: shifts store data/strobes up to the address lane and pulls load
// data down from it with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [31:0] st_lane,
  output logic [3:0]  st_strb,
  output logic [31:0] ld_data
);
  logic [4:0]  sh;
  logic [31:0] lane;

  assign sh      = {off, 3'b000};
  assign st_lane = st_data << sh;
  assign st_strb = strb_gen(size, off);
  assign lane    = ld_raw >> sh;

  always_comb begin
    ld_data = lane;
    case (size)
      SZ_B:    ld_data = {{24{~uns & lane[7]}}, lane[7:0]};
      SZ_H:    ld_data = {{16{~uns & lane[15]}}, lane[15:0]};
      default: ld_data = lane;
    endcase
  end
endmodule

// File: rtl/lsu_axi_master.sv
// AXI4-Lite initiator for the LSU: one load or store at a time, registered channel outputs,
// aligned/extended load data and an error flag returned on the response port.
module lsu_axi_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  lsu_axi_master_if.master    axi,
  output lsu_state_e          state_dbg
);
  lsu_state_e        state_q, state_d;
  logic [1:0]        off_q, off_d, size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              arvalid_q, arvalid_d, rready_q, rready_d;
  logic              awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              rvalid_q, rvalid_d, err_q, err_d;
  logic [1:0]        off_sel, size_sel;
  logic              uns_sel, aw_hs, w_hs;
  logic [31:0]       st_lane, ld_data;
  logic [3:0]        st_strb;

  // Store steering uses the live request at acceptance; load extraction uses the latched one.
  assign off_sel  = (state_q == ST_IDLE) ? req_addr[1:0] : off_q;
  assign size_sel = (state_q == ST_IDLE) ? req_size      : size_q;
  assign uns_sel  = (state_q == ST_IDLE) ? req_unsigned  : uns_q;

  lsu_lane_align u_align (
    .off     (off_sel),
    .size    (size_sel),
    .uns     (uns_sel),
    .st_data (req_wdata),
    .ld_raw  (axi.rdata),
    .st_lane (st_lane),
    .st_strb (st_strb),
    .ld_data (ld_data)
  );

  assign aw_hs = awvalid_q & axi.awready;
  assign w_hs  = wvalid_q & axi.wready;

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    uns_d     = uns_q;
    araddr_d  = araddr_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rvalid_d  = rvalid_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (bad_access(req_size, req_addr[1:0])) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
          end else if (!req_we) begin
            state_d   = ST_RD_ADDR;
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
          end else begin
            state_d   = ST_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = st_lane;
            wstrb_d   = st_strb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
      end
      ST_RD_ADDR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (axi.rvalid) begin
          rready_d = 1'b0;
          rvalid_d = 1'b1;
          err_d    = (axi.rresp != RESP_OKAY);
          rdata_d  = (axi.rresp != RESP_OKAY) ? '0 : ld_data;
          state_d  = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axi.bvalid) begin
          bready_d = 1'b0;
          rvalid_d = 1'b1;
          err_d    = (axi.bresp != RESP_OKAY);
          rdata_d  = '0;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      araddr_q  <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      araddr_q  <= araddr_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  // Gate with rst so the core sees no acceptance while reset is held.
  assign req_ready   = (state_q == ST_IDLE) & rst;
  assign resp_valid  = rvalid_q;
  assign resp_err    = err_q;
  assign resp_rdata  = rdata_q;
  assign state_dbg   = state_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = {{(STRB_W-4){1'b0}}, wstrb_q};
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads with lane extraction, stores with skewed
// AW/W handshakes, error paths, response back-pressure and asynchronous reset.
module tb_lsu_axi_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  lsu_state_e  state_dbg;
  int          total = 0;
  int          passed = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  lsu_axi_master_if axi_if ();

  lsu_axi_master dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .axi          (axi_if),
    .state_dbg    (state_dbg)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] size, input logic uns);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    req_size = size; req_unsigned = uns;
    step();
    req_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk1({tag, "_resp_valid_drop"}, resp_valid, 1'b0);
    chk1({tag, "_req_ready_back"}, req_ready, 1'b1);
  endtask

  task automatic load_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] rd, input logic [1:0] rresp,
                          input int ar_wait, input logic [31:0] exp_data, input logic exp_err);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    issue(1'b0, addr, 32'h0, size, uns);
    chk1({tag, "_arvalid"}, axi_if.arvalid, 1'b1);
    chk32({tag, "_araddr"}, axi_if.araddr, addr);
    chk1({tag, "_req_ready_busy"}, req_ready, 1'b0);
    for (int i = 0; i < ar_wait; i++) begin
      step();
      chk1({tag, "_arvalid_hold"}, axi_if.arvalid, 1'b1);
    end
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    chk1({tag, "_arvalid_drop"}, axi_if.arvalid, 1'b0);
    chk1({tag, "_rready"}, axi_if.rready, 1'b1);
    axi_if.rvalid = 1'b1; axi_if.rdata = rd; axi_if.rresp = rresp;
    step();
    axi_if.rvalid = 1'b0;
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk32({tag, "_rdata"}, resp_rdata, exp_data);
    chk1({tag, "_err"}, resp_err, exp_err);
    chk1({tag, "_rready_drop"}, axi_if.rready, 1'b0);
    finish_resp(tag);
  endtask

  task automatic store_txn(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, input int aw_dly, input int w_dly,
                           input logic [1:0] bresp, input logic [31:0] exp_wdata,
                           input logic [7:0] exp_strb, input logic exp_err, input int hold);
    int last;
    last = (aw_dly > w_dly) ? aw_dly : w_dly;
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    issue(1'b1, addr, wd, size, 1'b0);
    chk1({tag, "_awvalid"}, axi_if.awvalid, 1'b1);
    chk1({tag, "_wvalid"}, axi_if.wvalid, 1'b1);
    chk32({tag, "_awaddr"}, axi_if.awaddr, addr);
    chk32({tag, "_wdata"}, axi_if.wdata, exp_wdata);
    chk32({tag, "_wstrb"}, 32'(axi_if.wstrb), 32'(exp_strb));
    for (int c = 0; c <= last; c++) begin
      axi_if.awready = (c == aw_dly);
      axi_if.wready  = (c == w_dly);
      step();
      axi_if.awready = 1'b0;
      axi_if.wready  = 1'b0;
      chk1({tag, "_awvalid_seq"}, axi_if.awvalid, c < aw_dly);
      chk1({tag, "_wvalid_seq"}, axi_if.wvalid, c < w_dly);
    end
    chk1({tag, "_bready"}, axi_if.bready, 1'b1);
    axi_if.bvalid = 1'b1; axi_if.bresp = bresp;
    step();
    axi_if.bvalid = 1'b0;
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk1({tag, "_err"}, resp_err, exp_err);
    chk32({tag, "_rdata"}, resp_rdata, 32'h0);
    chk1({tag, "_bready_drop"}, axi_if.bready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk1({tag, "_hold_valid"}, resp_valid, 1'b1);
      chk1({tag, "_hold_err"}, resp_err, exp_err);
      chk32({tag, "_hold_rdata"}, resp_rdata, 32'h0);
      chk1({tag, "_hold_req_ready"}, req_ready, 1'b0);
    end
    finish_resp(tag);
  endtask

  task automatic err_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    issue(we, addr, 32'h5A5A5A5A, size, 1'b0);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk1({tag, "_err"}, resp_err, 1'b1);
    chk32({tag, "_rdata"}, resp_rdata, 32'h0);
    chk1({tag, "_arvalid"}, axi_if.arvalid, 1'b0);
    chk1({tag, "_awvalid"}, axi_if.awvalid, 1'b0);
    chk1({tag, "_wvalid"}, axi_if.wvalid, 1'b0);
    finish_resp(tag);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;
    axi_if.arready = 1'b0; axi_if.rdata = '0; axi_if.rresp = '0; axi_if.rvalid = 1'b0;
    axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.bresp = '0; axi_if.bvalid = 1'b0;
    repeat (2) step();
    chk1("rst_req_ready", req_ready, 1'b0);
    chk1("rst_arvalid", axi_if.arvalid, 1'b0);
    chk1("rst_awvalid", axi_if.awvalid, 1'b0);
    chk1("rst_wvalid", axi_if.wvalid, 1'b0);
    chk1("rst_rready", axi_if.rready, 1'b0);
    chk1("rst_bready", axi_if.bready, 1'b0);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk32("rst_araddr", axi_if.araddr, 32'h0);
    chk32("rst_wstrb", 32'(axi_if.wstrb), 32'h0);
    chk32("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b1;
    step();

    load_txn("lw_wait", 32'h8000_0004, SZ_W, 1'b0, 32'hDEAD_BEEF, 2'b00, 3, 32'hDEAD_BEEF, 1'b0);
    load_txn("lb", 32'h8000_0003, SZ_B, 1'b0, 32'h80AA_5511, 2'b00, 0, 32'hFFFF_FF80, 1'b0);
    load_txn("lbu", 32'h8000_0003, SZ_B, 1'b1, 32'h80AA_5511, 2'b00, 0, 32'h0000_0080, 1'b0);
    load_txn("lhu", 32'h8000_0002, SZ_H, 1'b1, 32'h80AA_5511, 2'b00, 0, 32'h0000_80AA, 1'b0);
    load_txn("lh_hi", 32'h8000_0002, SZ_H, 1'b0, 32'h80AA_5511, 2'b00, 1, 32'hFFFF_80AA, 1'b0);
    load_txn("lh_lo", 32'h8000_0000, SZ_H, 1'b0, 32'h80AA_5511, 2'b00, 0, 32'h0000_5511, 1'b0);
    load_txn("lb_1", 32'h8000_0001, SZ_B, 1'b0, 32'h80AA_5511, 2'b00, 0, 32'h0000_0055, 1'b0);
    load_txn("lw_slverr", 32'h8000_000C, SZ_W, 1'b0, 32'h1234_5678, 2'b10, 0, 32'h0, 1'b1);

    store_txn("sh", 32'h8000_0002, SZ_H, 32'h0000_1234, 0, 2, 2'b00,
              32'h1234_0000, 8'b0000_1100, 1'b0, 0);
    store_txn("sb", 32'h8000_0001, SZ_B, 32'h0000_00AB, 1, 1, 2'b00,
              32'h0000_AB00, 8'b0000_0010, 1'b0, 0);
    store_txn("sw_err", 32'h8000_0008, SZ_W, 32'hCAFE_F00D, 3, 1, 2'b10,
              32'hCAFE_F00D, 8'b0000_1111, 1'b1, 5);

    err_txn("lw_misalign", 1'b0, 32'h8000_0001, SZ_W);
    err_txn("sh_misalign", 1'b1, 32'h8000_0003, SZ_H);
    err_txn("rsv_size", 1'b1, 32'h8000_0000, 2'd3);

    // Stray read response while idle must not produce a response.
    axi_if.rvalid = 1'b1; axi_if.rdata = 32'hFFFF_FFFF;
    step();
    axi_if.rvalid = 1'b0;
    chk1("stray_r_resp_valid", resp_valid, 1'b0);
    chk32("stray_r_state", 32'(state_dbg), 32'(ST_IDLE));

    // Asynchronous reset while waiting in the read-data phase.
    issue(1'b0, 32'h8000_0010, 32'h0, SZ_W, 1'b0);
    axi_if.arready = 1'b1;
    step();
    axi_if.arready = 1'b0;
    chk1("arst_pre_rready", axi_if.rready, 1'b1);
    chk32("arst_pre_state", 32'(state_dbg), 32'(ST_RD_DATA));
    #2 rst = 1'b0;
    #1;
    chk1("arst_arvalid", axi_if.arvalid, 1'b0);
    chk1("arst_rready", axi_if.rready, 1'b0);
    chk1("arst_resp_valid", resp_valid, 1'b0);
    chk1("arst_req_ready", req_ready, 1'b0);
    chk32("arst_araddr", axi_if.araddr, 32'h0);
    chk32("arst_state", 32'(state_dbg), 32'(ST_IDLE));
    step();
    rst = 1'b1;
    step();
    load_txn("lw_post_rst", 32'h0000_0010, SZ_W, 1'b0, 32'h0123_4567, 2'b00, 0,
             32'h0123_4567, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
